mouse_cursor_tracker: RTL and testbench

Upstream of color_mapper. Consumes decoded PS/2 mouse bytes and assembles 3-byte movement packets. Accumulates signed deltas into a clamped on-screen cursor position. Publishes MouseX/MouseY and button state once per frame, so the cursor never tears mid-scan.

---
 rtl/mouse_pkg.sv | 33 +++
 rtl/mouse_axis_clamp.sv | 26 ++
 rtl/mouse_cursor_tracker.sv | 156 +++++++++++++++
 tb/tb_mouse_cursor_tracker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse path: packet FSM states, byte 0 field
// positions and the screen extents that color_mapper and the VGA controller also use.
package mouse_pkg;

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, APPLY} state_e;

  localparam int B0_L    = 0;
  localparam int B0_R    = 1;
  localparam int B0_M    = 2;
  localparam int B0_SYNC = 3;
  localparam int B0_XS   = 4;
  localparam int B0_YS   = 5;
  localparam int B0_XO   = 6;
  localparam int B0_YO   = 7;

  localparam int H_MAX = 639;
  localparam int V_MAX = 479;

  // Only the byte 0 fields the datapath needs are kept between bytes.
  typedef struct packed {
    logic yo;
    logic xo;
    logic ys;
    logic xs;
    logic r;
    logic l;
  } hdr_t;

  function automatic logic signed [10:0] delta9(input logic s, input logic [7:0] b);
    return $signed({s, s, s, b});
  endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// One cursor axis: adds a signed delta to the current position and saturates to [0, MAX].
module mouse_axis_clamp #(
  parameter int MAX = 639
) (
  input  logic [9:0]  pos_i,
  input  logic [10:0] delta_i,
  output logic [9:0]  pos_o
);
  localparam logic signed [11:0] MAX_S = 12'(MAX);
  localparam logic [9:0]         MAX_U = 10'(MAX);

  // One guard bit beyond the delta width so a doubled delta cannot wrap.
  logic signed [11:0] pos_s;
  logic signed [11:0] del_s;
  logic signed [11:0] sum;

  always_comb begin
    pos_s = $signed({2'b00, pos_i});
    del_s = $signed({delta_i[10], delta_i});
    sum   = pos_s + del_s;
    if (sum < 12'sd0)       pos_o = '0;
    else if (sum > MAX_S)   pos_o = MAX_U;
    else                    pos_o = sum[9:0];
  end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Assembles PS/2 movement packets into a clamped cursor and publishes it per frame.
// Optional MOUSE_ACCEL_EN doubles any axis delta whose magnitude reaches ACCEL_THRESH.
module mouse_cursor_tracker #(
  parameter int H_MAX        = mouse_pkg::H_MAX,
  parameter int V_MAX        = mouse_pkg::V_MAX,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int TIMEOUT_CYC  = 50000,
  parameter int ACCEL_THRESH = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       frame_start,
  output logic [9:0] MouseX,
  output logic [9:0] MouseY,
  output logic       left_btn,
  output logic       right_btn,
  output logic       left_click,
  output logic       sync_err
);
  import mouse_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);
  localparam logic signed [10:0] TH = 11'(ACCEL_THRESH);
`ifdef MOUSE_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  state_e        state_q, state_d;
  hdr_t          hdr_q, hdr_d;
  logic [7:0]    bx_q, bx_d, by_q, by_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic          pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [9:0]    mx_q, mx_d, my_q, my_d;
  logic          lb_q, lb_d, rb_q, rb_d, click_q, click_d, serr_q, serr_d;

  logic timeout, cap_b0, cap_x, cap_y, do_apply, reject;
  logic signed [10:0] dx, dy, dx_eff, dy_eff, dy_neg;
  logic [9:0] nx, ny;

  assign timeout = (state_q == WAIT_B1 || state_q == WAIT_B2) && (cnt_q == TMO);

  // FSM: state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= WAIT_B0;
    else        state_q <= state_d;
  end

  // FSM: next state; a timeout wins over a byte arriving on the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_B0: if (byte_valid && byte_data[B0_SYNC]) state_d = WAIT_B1;
      WAIT_B1: if (timeout) state_d = WAIT_B0; else if (byte_valid) state_d = WAIT_B2;
      WAIT_B2: if (timeout) state_d = WAIT_B0; else if (byte_valid) state_d = APPLY;
      APPLY:   state_d = WAIT_B0;
      default: state_d = WAIT_B0;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cap_b0   = (state_q == WAIT_B0) && byte_valid && byte_data[B0_SYNC];
    reject   = (state_q == WAIT_B0) && byte_valid && !byte_data[B0_SYNC];
    cap_x    = (state_q == WAIT_B1) && byte_valid && !timeout;
    cap_y    = (state_q == WAIT_B2) && byte_valid && !timeout;
    do_apply = (state_q == APPLY);
    serr_d   = reject || timeout;
  end

  always_comb begin
    hdr_d = hdr_q;
    bx_d  = cap_x ? byte_data : bx_q;
    by_d  = cap_y ? byte_data : by_q;
    if (cap_b0)
      hdr_d = '{yo: byte_data[B0_YO], xo: byte_data[B0_XO], ys: byte_data[B0_YS],
                xs: byte_data[B0_XS], r: byte_data[B0_R], l: byte_data[B0_L]};
    if (byte_valid || timeout || !(state_q == WAIT_B1 || state_q == WAIT_B2))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    dx     = hdr_q.xo ? 11'sd0 : delta9(hdr_q.xs, bx_q);
    dy     = hdr_q.yo ? 11'sd0 : delta9(hdr_q.ys, by_q);
    dx_eff = (ACCEL_ON && (dx >= TH || dx <= -TH)) ? (dx <<< 1) : dx;
    dy_eff = (ACCEL_ON && (dy >= TH || dy <= -TH)) ? (dy <<< 1) : dy;
    // PS/2 +Y points up, screen +Y points down.
    dy_neg = -dy_eff;
  end

  mouse_axis_clamp #(.MAX(H_MAX)) u_clamp_x (.pos_i(pend_x_q), .delta_i(dx_eff), .pos_o(nx));
  mouse_axis_clamp #(.MAX(V_MAX)) u_clamp_y (.pos_i(pend_y_q), .delta_i(dy_neg), .pos_o(ny));

  always_comb begin
    pend_x_d = do_apply ? nx      : pend_x_q;
    pend_y_d = do_apply ? ny      : pend_y_q;
    pend_l_d = do_apply ? hdr_q.l : pend_l_q;
    pend_r_d = do_apply ? hdr_q.r : pend_r_q;
    // Publishing reads the pending flops, so an APPLY on the same edge lands next frame.
    mx_d    = frame_start ? pend_x_q : mx_q;
    my_d    = frame_start ? pend_y_q : my_q;
    lb_d    = frame_start ? pend_l_q : lb_q;
    rb_d    = frame_start ? pend_r_q : rb_q;
    click_d = frame_start && pend_l_q && !lb_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hdr_q    <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      cnt_q    <= '0;
      pend_x_q <= 10'(X_INIT);
      pend_y_q <= 10'(Y_INIT);
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
      mx_q     <= 10'(X_INIT);
      my_q     <= 10'(Y_INIT);
      lb_q     <= 1'b0;
      rb_q     <= 1'b0;
      click_q  <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      hdr_q    <= hdr_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      cnt_q    <= cnt_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      lb_q     <= lb_d;
      rb_q     <= rb_d;
      click_q  <= click_d;
      serr_q   <= serr_d;
    end
  end

  assign MouseX     = mx_q;
  assign MouseY     = my_q;
  assign left_btn   = lb_q;
  assign right_btn  = rb_q;
  assign left_click = click_q;
  assign sync_err   = serr_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed plus randomized checks of the mouse tracker against an integer cursor model.
module tb_mouse_cursor_tracker;
  localparam int TO    = 100;
  localparam int HMAX  = 639;
  localparam int VMAX  = 479;
  localparam int THRESH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic       frame_start = 1'b0;
  logic [9:0] mouse_x, mouse_y;
  logic       left_btn, right_btn, left_click, sync_err;

  int ncmp = 0;
  int nfail = 0;
  // Model: pending and published cursor state
  int px = 320, py = 240, pl = 0, pr = 0;
  int qx = 320, qy = 240, ql = 0, qr = 0, qclick = 0;

  mouse_cursor_tracker #(.TIMEOUT_CYC(TO), .ACCEL_THRESH(THRESH)) dut (
    .Clk(clk), .Reset(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_start(frame_start), .MouseX(mouse_x), .MouseY(mouse_y),
    .left_btn(left_btn), .right_btn(right_btn), .left_click(left_click),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic int scale(input int d);
`ifdef MOUSE_ACCEL_EN
    if (d >= THRESH || d <= -THRESH) return d * 2;
`endif
    return d;
  endfunction

  task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = int'(b1) - (b0[4] ? 256 : 0);
    dy = int'(b2) - (b0[5] ? 256 : 0);
    if (b0[6]) dx = 0;
    if (b0[7]) dy = 0;
    px = clampi(px + scale(dx), HMAX);
    py = clampi(py - scale(dy), VMAX);
    pl = b0[0];
    pr = b0[1];
  endtask

  task automatic model_publish();
    qclick = (pl == 1 && ql == 0) ? 1 : 0;
    qx = px; qy = py; ql = pl; qr = pr;
  endtask

  task automatic check_pub(input string tag);
    chk({tag, ".x"}, 32'(mouse_x), 32'(qx));
    chk({tag, ".y"}, 32'(mouse_y), 32'(qy));
    chk({tag, ".l"}, 32'(left_btn), 32'(ql));
    chk({tag, ".r"}, 32'(right_btn), 32'(qr));
    chk({tag, ".click"}, 32'(left_click), 32'(qclick));
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_data = b; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0); send_byte(b1); send_byte(b2);
    model_apply(b0, b1, b2);
  endtask

  task automatic do_frame(input string tag);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_publish();
    check_pub(tag);
    tick();
    chk({tag, ".click_off"}, 32'(left_click), 32'd0);
  endtask

  task automatic move_x_to(input int target);
    int d;
    for (int k = 0; k < 20 && px != target; k++) begin
      d = target - px;
      if (d > 255) d = 255;
      if (d < -255) d = -255;
      send_pkt((d < 0) ? 8'h18 : 8'h08, 8'(d), 8'h00);
    end
  endtask

  initial begin
    int n;
    logic [7:0] r0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset.serr", 32'(sync_err), 32'd0);
    do_frame("reset");

    send_pkt(8'h08, 8'h05, 8'h00);
    chk("prepub.x", 32'(mouse_x), 32'd320);
    do_frame("dx_p5");

    send_pkt(8'h18, 8'hF6, 8'h0A);
    do_frame("dx_m10");

    move_x_to(635);
    send_pkt(8'h08, 8'd10, 8'h00);
    do_frame("clamp_hi");
    move_x_to(3);
    send_pkt(8'h18, 8'hF6, 8'h00);
    do_frame("clamp_lo");
    send_pkt(8'h48, 8'h05, 8'h00);
    do_frame("x_ovf");

    // Rejected header byte
    byte_data = 8'h00; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    chk("reject.serr", 32'(sync_err), 32'd1);
    tick();
    chk("reject.serr_off", 32'(sync_err), 32'd0);
    do_frame("reject");

    // Partial packet abandoned by timeout
    byte_data = 8'h09; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    n = 0;
    while (sync_err !== 1'b1 && n <= TO + 10) begin
      tick();
      n++;
    end
    chk("tmo.fire", 32'(n >= TO && n <= TO + 2), 32'd1);
    tick();
    chk("tmo.serr_off", 32'(sync_err), 32'd0);
    send_pkt(8'h09, 8'h01, 8'h00);
    do_frame("after_tmo");
    chk("after_tmo.serr", 32'(sync_err), 32'd0);

    // Frame start coincident with APPLY
    send_byte(8'h08); send_byte(8'h05);
    byte_data = 8'h00; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_publish();
    model_apply(8'h08, 8'h05, 8'h00);
    check_pub("coinc");
    repeat (3) tick();
    do_frame("coinc_next");

    // Randomized packets
    for (int i = 0; i < 24; i++) begin
      r0 = 8'($urandom);
      r0[3] = 1'b1;
      if ($urandom_range(0, 7) != 0) r0[7:6] = 2'b00;
      send_pkt(r0, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) do_frame($sformatf("rand%0d", i));
    end
    do_frame("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
